// File: rtl/data_mem_hs_if.sv
// Request/response handshake bundle between a CPU load/store master and the data memory.
// The master drives the request fields and rsp_ready; the memory drives everything else.
interface data_mem_hs_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_hs.sv
// Data memory slave: one transaction at a time, WAIT_CYCLES wait states between accept and
// commit, then a response held until the master takes it. Byte-enabled stores, range errors.
module data_mem_hs #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 7,
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  data_mem_hs_if.slave  bus
);
  localparam int                BE_W    = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic                hold_write;
  logic [ADDR_W-1:0]   hold_addr;
  logic [DATA_W-1:0]   hold_wdata;
  logic [BE_W-1:0]     hold_be;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                commit;
  logic                in_range;
  logic                cur_write;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_wdata;
  logic [BE_W-1:0]     cur_be;

  // With zero wait states the commit happens on the accept edge, so the live request
  // fields are used in IDLE and the captured copy afterwards.
  // NOTE: combinational logic uses blocking '=' with a default for every output, so no latch is inferred.
  always_comb begin
    accept    = rst_n && (state == S_IDLE) && bus.req_valid;
    commit    = (accept && (WAIT_CYCLES == 0)) ||
                (rst_n && (state == S_WAIT) && (cnt == 4'd0));
    cur_write = hold_write;
    cur_addr  = hold_addr;
    cur_wdata = hold_wdata;
    cur_be    = hold_be;
    if (state == S_IDLE) begin
      cur_write = bus.req_write;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
      cur_be    = bus.req_be;
    end
    in_range  = {1'b0, cur_addr} < DEPTH_L;
  end

  assign bus.req_ready = rst_n && (state == S_IDLE);

  // NOTE: sequential state uses non-blocking '<=' so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      hold_write    <= 1'b0;
      hold_addr     <= '0;
      hold_wdata    <= '0;
      hold_be       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            hold_write <= bus.req_write;
            hold_addr  <= bus.req_addr;
            hold_wdata <= bus.req_wdata;
            hold_be    <= bus.req_be;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              cnt   <= 4'(WAIT_CYCLES - 1);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state         <= S_IDLE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (commit) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= !in_range;
        bus.rsp_rdata <= (!cur_write && in_range) ? mem[cur_addr] : '0;
      end
    end
  end

  // NOTE: the array has no reset; its contents are undefined until written, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (commit && cur_write && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (cur_be[i]) mem[cur_addr][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_data_mem_hs.sv
// Bench for data_mem_hs: three instances (1 wait/DEPTH 100, 3 waits, 0 waits) checked against
// an array-based model of the memory, with directed vectors, random traffic and reset cases.
module tb_data_mem_hs;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_hs_if #(.DATA_W(32), .ADDR_W(7)) bus0 ();
  data_mem_hs_if #(.DATA_W(32), .ADDR_W(7)) bus1 ();
  data_mem_hs_if #(.DATA_W(32), .ADDR_W(7)) bus2 ();

  data_mem_hs #(.DATA_W(32), .ADDR_W(7), .DEPTH(100), .WAIT_CYCLES(1))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  data_mem_hs #(.DATA_W(32), .ADDR_W(7), .DEPTH(128), .WAIT_CYCLES(3))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  data_mem_hs #(.DATA_W(32), .ADDR_W(7), .DEPTH(128), .WAIT_CYCLES(0))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic        q_valid [3];
  logic        q_write [3];
  logic [6:0]  q_addr  [3];
  logic [31:0] q_wdata [3];
  logic [3:0]  q_be    [3];
  logic        r_ready [3];
  logic        s_ready [3];
  logic        r_valid [3];
  logic [31:0] r_rdata [3];
  logic        r_err   [3];

  assign bus0.req_valid = q_valid[0]; assign bus0.req_write = q_write[0];
  assign bus0.req_addr  = q_addr[0];  assign bus0.req_wdata = q_wdata[0];
  assign bus0.req_be    = q_be[0];    assign bus0.rsp_ready = r_ready[0];
  assign s_ready[0] = bus0.req_ready; assign r_valid[0] = bus0.rsp_valid;
  assign r_rdata[0] = bus0.rsp_rdata; assign r_err[0]   = bus0.rsp_err;

  assign bus1.req_valid = q_valid[1]; assign bus1.req_write = q_write[1];
  assign bus1.req_addr  = q_addr[1];  assign bus1.req_wdata = q_wdata[1];
  assign bus1.req_be    = q_be[1];    assign bus1.rsp_ready = r_ready[1];
  assign s_ready[1] = bus1.req_ready; assign r_valid[1] = bus1.rsp_valid;
  assign r_rdata[1] = bus1.rsp_rdata; assign r_err[1]   = bus1.rsp_err;

  assign bus2.req_valid = q_valid[2]; assign bus2.req_write = q_write[2];
  assign bus2.req_addr  = q_addr[2];  assign bus2.req_wdata = q_wdata[2];
  assign bus2.req_be    = q_be[2];    assign bus2.rsp_ready = r_ready[2];
  assign s_ready[2] = bus2.req_ready; assign r_valid[2] = bus2.rsp_valid;
  assign r_rdata[2] = bus2.rsp_rdata; assign r_err[2]   = bus2.rsp_err;

  int depth_of [3] = '{100, 128, 128};
  int wait_of  [3] = '{1, 3, 0};
  logic [31:0] model [3][128];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          d;
    bit          wr;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Reference behaviour: a word array per instance, byte-merged stores, anything past DEPTH is an error.
  task automatic model_step(input int d, input bit wr, input logic [6:0] a, input logic [31:0] wd,
                            input logic [3:0] be, output logic [31:0] er, output logic ee);
    ee = (int'(a) >= depth_of[d]);
    er = 32'h0;
    if (!ee) begin
      if (wr) begin
        for (int i = 0; i < 4; i++) if (be[i]) model[d][a][8*i +: 8] = wd[8*i +: 8];
      end else begin
        er = model[d][a];
      end
    end
  endtask

  task automatic start_req(input int d, input bit wr, input logic [6:0] a, input logic [31:0] wd,
                           input logic [3:0] be, output bit ok);
    int n = 0;
    @(negedge clk);
    q_valid[d] = 1'b1; q_write[d] = wr; q_addr[d] = a; q_wdata[d] = wd; q_be[d] = be;
    while (!s_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready[d]) begin
      check($sformatf("accept_timeout_d%0d", d), 32'd0, 32'd1);
      q_valid[d] = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    #1 q_valid[d] = 1'b0;
    ok = 1'b1;
  endtask

  task automatic finish_rsp(input int d, input int hold, input logic [31:0] exp_rd,
                            input logic exp_err, input string tag);
    int lat = 1;
    @(negedge clk);
    while (!r_valid[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, wait_of[d] + 1);
    if (!r_valid[d]) return;
    check({tag, "_rdata"}, r_rdata[d], exp_rd);
    check({tag, "_err"}, {31'b0, r_err[d]}, {31'b0, exp_err});
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, "_bp_valid"}, {31'b0, r_valid[d]}, 32'd1);
      check({tag, "_bp_rdata"}, r_rdata[d], exp_rd);
      check({tag, "_bp_err"}, {31'b0, r_err[d]}, {31'b0, exp_err});
      check({tag, "_bp_req_ready"}, {31'b0, s_ready[d]}, 32'd0);
    end
    r_ready[d] = 1'b1;
    @(posedge clk);
    #1 r_ready[d] = 1'b0;
    @(negedge clk);
    check({tag, "_done_valid"}, {31'b0, r_valid[d]}, 32'd0);
    check({tag, "_done_rdata"}, r_rdata[d], 32'h0);
    check({tag, "_done_idle"}, {31'b0, s_ready[d]}, 32'd1);
  endtask

  // One full transaction; the model is always updated, but the expectation may come from a table.
  task automatic run(input int d, input bit wr, input logic [6:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input int hold, input bit use_exp,
                     input logic [31:0] t_rd, input logic t_err, input string tag);
    logic [31:0] m_rd;
    logic        m_err;
    bit          ok;
    model_step(d, wr, a, wd, be, m_rd, m_err);
    start_req(d, wr, a, wd, be, ok);
    if (!ok) return;
    if (use_exp) finish_rsp(d, hold, t_rd, t_err, tag);
    else         finish_rsp(d, hold, m_rd, m_err, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dummy_rd;
    logic        dummy_err;
    bit          ok;

    vecs[0]  = '{0, 1'b1, 7'd5,   32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0};
    vecs[1]  = '{0, 1'b0, 7'd5,   32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{0, 1'b1, 7'd9,   32'h11223344, 4'hF, 0, 32'h0,        1'b0};
    vecs[3]  = '{0, 1'b1, 7'd9,   32'hAABBCCDD, 4'h5, 0, 32'h0,        1'b0};
    vecs[4]  = '{0, 1'b0, 7'd9,   32'h0,        4'h0, 5, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{0, 1'b0, 7'd120, 32'h0,        4'h0, 0, 32'h0,        1'b1};
    vecs[6]  = '{0, 1'b1, 7'd120, 32'h12345678, 4'hF, 1, 32'h0,        1'b1};
    vecs[7]  = '{0, 1'b1, 7'd99,  32'hCAFEF00D, 4'hF, 0, 32'h0,        1'b0};
    vecs[8]  = '{0, 1'b0, 7'd99,  32'h0,        4'h0, 0, 32'hCAFEF00D, 1'b0};
    vecs[9]  = '{0, 1'b0, 7'd100, 32'h0,        4'h0, 0, 32'h0,        1'b1};
    vecs[10] = '{0, 1'b1, 7'd100, 32'hFFFFFFFF, 4'hF, 0, 32'h0,        1'b1};
    vecs[11] = '{0, 1'b0, 7'd127, 32'h0,        4'h0, 0, 32'h0,        1'b1};
    vecs[12] = '{0, 1'b1, 7'd5,   32'h01020304, 4'h0, 0, 32'h0,        1'b0};
    vecs[13] = '{0, 1'b0, 7'd5,   32'h0,        4'h0, 2, 32'hDEADBEEF, 1'b0};
    vecs[14] = '{1, 1'b1, 7'd3,   32'h0000FFFF, 4'hF, 0, 32'h0,        1'b0};
    vecs[15] = '{1, 1'b0, 7'd3,   32'h0,        4'h0, 1, 32'h0000FFFF, 1'b0};
    vecs[16] = '{2, 1'b1, 7'd3,   32'hFFFFFFFF, 4'hF, 0, 32'h0,        1'b0};
    vecs[17] = '{2, 1'b1, 7'd3,   32'h00000000, 4'h6, 0, 32'h0,        1'b0};

    for (int d = 0; d < 3; d++) begin
      q_valid[d] = 1'b0; q_write[d] = 1'b0; q_addr[d] = '0;
      q_wdata[d] = '0;   q_be[d]    = '0;   r_ready[d] = 1'b0;
    end

    // Power-on reset
    #12;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("por_valid_d%0d", d), {31'b0, r_valid[d]}, 32'd0);
      check($sformatf("por_rdata_d%0d", d), r_rdata[d], 32'h0);
      check($sformatf("por_err_d%0d", d), {31'b0, r_err[d]}, 32'd0);
      check($sformatf("por_ready_low_d%0d", d), {31'b0, s_ready[d]}, 32'd0);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    for (int d = 0; d < 3; d++)
      check($sformatf("por_ready_high_d%0d", d), {31'b0, s_ready[d]}, 32'd1);

    // Give every in-range word a known value
    for (int d = 0; d < 3; d++)
      for (int a = 0; a < depth_of[d]; a++)
        run(d, 1'b1, 7'(a), $urandom, 4'hF, 0, 1'b0, 32'h0, 1'b0, "prefill");

    // Directed vectors, then the full model is compared back through loads (dut0 must be untouched by errors)
    for (int v = 0; v < 18; v++)
      run(vecs[v].d, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].be, vecs[v].hold,
          1'b1, vecs[v].exp_rdata, vecs[v].exp_err, $sformatf("vec%0d", v));
    run(2, 1'b0, 7'd3, 32'h0, 4'h0, 0, 1'b1, 32'hFF0000FF, 1'b0, "vec_be_mid");
    for (int a = 0; a < 100; a++)
      run(0, 1'b0, 7'(a), 32'h0, 4'h0, 0, 1'b0, 32'h0, 1'b0, "sweep0");

    // Random traffic against the model
    for (int n = 0; n < 150; n++)
      run(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
          $urandom, 4'($urandom), int'($urandom_range(0, 3)), 1'b0, 32'h0, 1'b0, "rand");

    // Async reset while a load response is being held
    start_req(0, 1'b0, 7'd5, 32'h0, 4'h0, ok);
    for (int n = 0; n < 5 && !r_valid[0]; n++) @(negedge clk);
    check("mid_rst_pre_valid", {31'b0, r_valid[0]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, r_valid[0]}, 32'd0);
    check("mid_rst_rdata", r_rdata[0], 32'h0);
    check("mid_rst_err", {31'b0, r_err[0]}, 32'd0);
    check("mid_rst_ready", {31'b0, s_ready[0]}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("mid_rst_release_ready", {31'b0, s_ready[0]}, 32'd1);

    // Reset during WAIT discards a pending store (3 wait states)
    run(1, 1'b1, 7'd2, 32'h0, 4'hF, 0, 1'b0, 32'h0, 1'b0, "w3_clear");
    start_req(1, 1'b1, 7'd2, 32'h12345678, 4'hF, ok);
    @(negedge clk);
    check("w3_still_waiting", {31'b0, r_valid[1]}, 32'd0);
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    run(1, 1'b0, 7'd2, 32'h0, 4'h0, 0, 1'b1, 32'h0, 1'b0, "w3_after_rst");

    // Zero wait states: committed on accept, response next cycle, reset only drops the response
    run(2, 1'b1, 7'd2, 32'h0, 4'hF, 0, 1'b0, 32'h0, 1'b0, "w0_clear");
    start_req(2, 1'b1, 7'd2, 32'h12345678, 4'hF, ok);
    model_step(2, 1'b1, 7'd2, 32'h12345678, 4'hF, dummy_rd, dummy_err);
    @(negedge clk);
    check("w0_rsp_next_cycle", {31'b0, r_valid[2]}, 32'd1);
    rst_n = 1'b0;
    #1 check("w0_rsp_dropped", {31'b0, r_valid[2]}, 32'd0);
    #2 rst_n = 1'b1;
    run(2, 1'b0, 7'd2, 32'h0, 4'h0, 0, 1'b1, 32'h12345678, 1'b0, "w0_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
